// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read ports, write ports, issue strobe and scoreboard view.
// Latency: none of its own; wires only.
// Backpressure: none; the issue stage consults busy_vec/rd_busy before using a read.
interface regfile_mp_if #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1
);
  localparam int AW = $clog2(REG_COUNT);

  // Read side (decode/issue)
  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;

  // Write side (writeback)
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;

  // Scoreboard set and view
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic [REG_COUNT-1:0]   busy_vec;

  // Pipeline side: drives reads, writes and issues
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  // Register file side
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hard-wired, write-to-read bypass and pending-write scoreboard.
// Latency: reads are combinational (0 cycles); writes and scoreboard updates land on the next clk edge.
// Backpressure: none; rd_busy flags a read whose producer is still in flight so issue can stall.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter bit BYPASS    = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave rf
);
  localparam int AW = $clog2(REG_COUNT);

  // Unpacked views of the flat write buses; wr_vld already excludes x0 so
  // nothing downstream needs to special-case it again.
  logic [AW-1:0]     wr_addr_w [NUM_WR];
  logic [XLEN-1:0]   wr_data_w [NUM_WR];
  logic [NUM_WR-1:0] wr_vld;

  // Storage and scoreboard as seen by the read ports; entry 0 is constant zero.
  logic [XLEN-1:0]      rf_q [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;

  logic [NUM_RD*XLEN-1:0] rd_data_c;
  logic [NUM_RD-1:0]      rd_busy_c;

  // Split the write buses and qualify each port with a non-zero address
  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      wr_addr_w[k] = rf.wr_addr[k*AW +: AW];
      wr_data_w[k] = rf.wr_data[k*XLEN +: XLEN];
      wr_vld[k]    = rf.wr_en[k] && (rf.wr_addr[k*AW +: AW] != '0);
    end
  end

  assign rf_q[0]   = '0;
  assign busy_q[0] = 1'b0;

  // One block per architectural register so each shows up as g_reg[i].q /
  // g_reg[i].busy in waveforms.
  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    logic [XLEN-1:0] q;
    logic            busy;
    logic            wr_hit;
    logic [XLEN-1:0] wr_val;
    logic            iss_hit;

    // Write-port decode; later ports override earlier ones on a collision
    always_comb begin
      wr_hit = 1'b0;
      wr_val = q;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_vld[k] && (wr_addr_w[k] == AW'(i))) begin
          wr_hit = 1'b1;
          wr_val = wr_data_w[k];
        end
      end
    end

    assign iss_hit = rf.iss_en && (rf.iss_addr == AW'(i));

    // Register contents; an async reset in the middle of a write discards it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (wr_hit) begin
        q <= wr_val;
      end
    end

    // Pending-write bit; a new issue beats a retiring write in the same cycle
    // because the newer producer is the one still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy <= 1'b0;
      end else if (iss_hit) begin
        busy <= 1'b1;
      end else if (wr_hit) begin
        busy <= 1'b0;
      end
    end

    assign rf_q[i]   = q;
    assign busy_q[i] = busy;
  end : g_reg

  // Per-read-port mux, bypass and hazard flag
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            hit;
    logic            live;

    assign addr = rf.rd_addr[p*AW +: AW];
    // Reads of x0, disabled ports and reads during reset all return zero.
    assign live = rst_n && rf.rd_en[p] && (addr != '0);

    // Stored value, overridden by the highest-index same-cycle write when bypassing
    always_comb begin
      hit  = 1'b0;
      data = rf_q[addr];
      if (BYPASS) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_vld[k] && (wr_addr_w[k] == addr)) begin
            hit  = 1'b1;
            data = wr_data_w[k];
          end
        end
      end
    end

    // Without bypass hit never rises, so a same-cycle write does not hide busy.
    assign rd_data_c[p*XLEN +: XLEN] = live ? data : '0;
    assign rd_busy_c[p]              = live && busy_q[addr] && !hit;
  end : g_rd

  assign rf.rd_data  = rd_data_c;
  assign rf.rd_busy  = rd_busy_c;
  // Registered scoreboard only; same-cycle issue/write effects show next cycle.
  assign rf.busy_vec = rst_n ? busy_q : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing dual-write instance and one non-bypassing single-write instance.
// Latency: reads checked 1-2 time units after inputs change; state checked one clock later.
// Backpressure: none.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(2)) ifa ();
  regfile_mp_if #(.XLEN(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(1)) ifb ();

  regfile_mp #(.XLEN(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (ifa)
  );

  regfile_mp #(.XLEN(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (ifb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.rd_en = '0; ifa.rd_addr = '0; ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.iss_en = 1'b0; ifa.iss_addr = '0;
    ifb.rd_en = '0; ifb.rd_addr = '0; ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.iss_en = 1'b0; ifb.iss_addr = '0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    tick();
    tick();

    // In reset: even a bypassable write must not reach rd_data
    ifa.rd_en = 2'b11; ifa.rd_addr = {5'd5, 5'd5};
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd5}; ifa.wr_data = {32'h0, 32'hDEADBEEF};
    #1;
    chk("rst_rd_data", 64'(ifa.rd_data), 64'h0);
    chk("rst_busy_vec", 64'(ifa.busy_vec), 64'h0);
    chk("rst_rd_busy", 64'(ifa.rd_busy), 64'h0);

    // Leave reset, then write x5 and issue x5 together (set wins over clear)
    idle();
    rst_n = 1'b1;
    tick();
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd5}; ifa.wr_data = {32'h0, 32'hDEADBEEF};
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd5;
    tick();
    idle();
    ifa.rd_en = 2'b01; ifa.rd_addr = {5'd0, 5'd5};
    #1;
    chk("x5_written", 64'(ifa.rd_data[31:0]), 64'hDEADBEEF);
    chk("x5_busy_vec", 64'(ifa.busy_vec), 64'h20);
    chk("x5_rd_busy", 64'(ifa.rd_busy), 64'h1);

    // Mid-cycle async reset, with a write to x6 pending across the edge
    #1;
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd6}; ifa.wr_data = {32'h0, 32'h00000077};
    rst_n = 1'b0;
    #1;
    chk("async_rst_x5", 64'(ifa.rd_data[31:0]), 64'h0);
    chk("async_rst_busy_vec", 64'(ifa.busy_vec), 64'h0);
    tick();
    rst_n = 1'b1;
    idle();
    ifa.rd_en = 2'b11; ifa.rd_addr = {5'd6, 5'd5};
    #1;
    chk("after_rst_x6_x5", 64'(ifa.rd_data), 64'h0);

    // x0: writes on both ports, issue to x0, reads on both ports
    tick();
    ifa.wr_en = 2'b11; ifa.wr_addr = {5'd0, 5'd0}; ifa.wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd0;
    ifa.rd_en = 2'b11; ifa.rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0_rd_data_same", 64'(ifa.rd_data), 64'h0);
    chk("x0_rd_busy_same", 64'(ifa.rd_busy), 64'h0);
    tick();
    idle();
    ifa.rd_en = 2'b11; ifa.rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0_rd_data_next", 64'(ifa.rd_data), 64'h0);
    chk("x0_busy_vec", 64'(ifa.busy_vec), 64'h0);

    // Bypass on: same-cycle read of x7 sees the new value
    tick();
    idle();
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd7}; ifa.wr_data = {32'h0, 32'h12345678};
    ifa.rd_en = 2'b01; ifa.rd_addr = {5'd0, 5'd7};
    #1;
    chk("a_x7_bypass", 64'(ifa.rd_data[31:0]), 64'h12345678);
    tick();
    ifa.wr_en = 2'b00;
    #1;
    chk("a_x7_next", 64'(ifa.rd_data[31:0]), 64'h12345678);

    // Bypass off: x7 = 1 first, then a same-cycle read sees the old value
    tick();
    idle();
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd7; ifb.wr_data = 32'h1;
    tick();
    ifb.wr_data = 32'h12345678;
    ifb.rd_en = 2'b01; ifb.rd_addr = {5'd0, 5'd7};
    #1;
    chk("b_x7_no_bypass", 64'(ifb.rd_data[31:0]), 64'h1);
    tick();
    ifb.wr_en = 1'b0;
    #1;
    chk("b_x7_next", 64'(ifb.rd_data[31:0]), 64'h12345678);

    // Dual write collision on x3: port 1 wins for bypass and storage
    tick();
    idle();
    ifa.wr_en = 2'b11; ifa.wr_addr = {5'd3, 5'd3}; ifa.wr_data = {32'hBBBB0000, 32'hAAAA0000};
    ifa.rd_en = 2'b10; ifa.rd_addr = {5'd3, 5'd0};
    #1;
    chk("collide_bypass", 64'(ifa.rd_data), {32'hBBBB0000, 32'h0});
    tick();
    ifa.wr_en = 2'b00;
    #1;
    chk("collide_stored", 64'(ifa.rd_data[63:32]), 64'hBBBB0000);

    // Dual write to distinct registers both land
    ifa.wr_en = 2'b11; ifa.wr_addr = {5'd11, 5'd10}; ifa.wr_data = {32'h11, 32'h10};
    tick();
    idle();
    ifa.rd_en = 2'b11; ifa.rd_addr = {5'd11, 5'd10};
    #1;
    chk("dual_distinct", 64'(ifa.rd_data), {32'h11, 32'h10});

    // Data without wr_en must not be stored
    ifa.wr_addr = {5'd0, 5'd12}; ifa.wr_data = {32'h0, 32'h99};
    tick();
    idle();
    ifa.rd_en = 2'b01; ifa.rd_addr = {5'd0, 5'd12};
    #1;
    chk("no_wr_en", 64'(ifa.rd_data[31:0]), 64'h0);

    // Scoreboard: issue x9 (cycle 0)
    tick();
    idle();
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd9;
    #1;
    chk("sb_same_cycle_vec", 64'(ifa.busy_vec), 64'h0);
    tick();                                   // cycle 1
    idle();
    ifa.rd_en = 2'b11; ifa.rd_addr = {5'd0, 5'd9};
    #1;
    chk("sb_busy_vec_c1", 64'(ifa.busy_vec), 64'h200);
    chk("sb_rd_busy_c1", 64'(ifa.rd_busy), 64'h1);
    tick();                                   // cycle 2
    tick();                                   // cycle 3: write retires
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd9}; ifa.wr_data = {32'h0, 32'h55};
    ifa.rd_addr = {5'd9, 5'd9};
    #1;
    chk("sb_rd_busy_c3", 64'(ifa.rd_busy), 64'h0);
    chk("sb_rd_data_c3", 64'(ifa.rd_data), {32'h55, 32'h55});
    chk("sb_busy_vec_c3", 64'(ifa.busy_vec), 64'h200);
    tick();                                   // cycle 4
    ifa.wr_en = 2'b00;
    #1;
    chk("sb_busy_vec_c4", 64'(ifa.busy_vec), 64'h0);

    // Without bypass the same-cycle write does not mask the hazard
    idle();
    ifb.iss_en = 1'b1; ifb.iss_addr = 5'd9;
    tick();
    idle();
    ifb.wr_en = 1'b1; ifb.wr_addr = 5'd9; ifb.wr_data = 32'h66;
    ifb.rd_en = 2'b01; ifb.rd_addr = {5'd0, 5'd9};
    #1;
    chk("b_sb_rd_busy", 64'(ifb.rd_busy), 64'h1);
    chk("b_sb_rd_data", 64'(ifb.rd_data[31:0]), 64'h0);
    tick();
    ifb.wr_en = 1'b0;
    #1;
    chk("b_sb_after", {31'h0, ifb.rd_busy[0], ifb.busy_vec}, 64'h0);
    chk("b_sb_data_after", 64'(ifb.rd_data[31:0]), 64'h66);

    // Set/clear race on x4
    idle();
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd4;
    tick();
    idle();
    #1;
    chk("race_pre_vec", 64'(ifa.busy_vec), 64'h10);
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd4}; ifa.wr_data = {32'h0, 32'h0000CAFE};
    ifa.iss_en = 1'b1; ifa.iss_addr = 5'd4;
    tick();
    idle();
    ifa.rd_en = 2'b01; ifa.rd_addr = {5'd0, 5'd4};
    #1;
    chk("race_busy_vec", 64'(ifa.busy_vec), 64'h10);
    chk("race_data", 64'(ifa.rd_data[31:0]), 64'hCAFE);
    chk("race_rd_busy", 64'(ifa.rd_busy), 64'h1);

    // Disabled port returns zero and no hazard even for a busy register
    ifa.rd_en = 2'b00;
    #1;
    chk("rd_disabled_data", 64'(ifa.rd_data), 64'h0);
    chk("rd_disabled_busy", 64'(ifa.rd_busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next-generation Lexington core. It generalises the single-write, two-read file.
- Configurable read-port count, write-port count, register count and data width.
- Adds write-to-read bypass, asynchronous clear of all registers, and a per-register pending-write scoreboard with per-read-port hazard flags.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- XLEN, 32, data width of each register in bits.
- REG_COUNT, 32, number of architectural registers (power of two, >=2); register 0 is hard-wired to zero.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return pre-write contents.
- AW, $clog2(REG_COUNT), derived address width; not overridable.

Ports:
- clk  in  1  clock for all state.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*AW  per-port read address.
- rd_data  out  NUM_RD*XLEN  per-port read data (combinational).
- rd_busy  out  NUM_RD  per-port hazard flag: the addressed register has a pending write not satisfied this cycle.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  per-port write address.
- wr_data  in  NUM_WR*XLEN  per-port write data.
- iss_en  in  1  issue strobe: mark iss_addr as pending.
- iss_addr  in  AW  destination register of the issued instruction.
- busy_vec  out  REG_COUNT  current scoreboard, bit i = register i pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers 1..REG_COUNT-1 clear to 0.
  - Scoreboard clears to all-zero.
  - Outputs while in reset: rd_data = 0, rd_busy = 0, busy_vec = 0.
  - Reset deassertion is sampled at a clk edge; the first write takes effect on the first rising edge with rst_n high.
  - Reset asserted mid-write discards that write.
- Register 0:
  - Reads always return 0, with rd_busy = 0.
  - Writes are ignored.
  - iss_en with iss_addr = 0 is ignored; busy_vec[0] is always 0.
- Reads:
  - Combinational, zero latency.
  - Port disabled (rd_en = 0) -> rd_data = 0, rd_busy = 0.
- Writes:
  - Take effect on rising clk when wr_en[k] = 1 and wr_addr[k] != 0.
  - Two write ports targeting the same address in the same cycle: the higher port index wins, for both storage and bypass.
- Bypass (BYPASS = 1):
  - If any enabled write port matches an enabled read address (non-zero), rd_data returns that wr_data, using the highest matching port.
  - With BYPASS = 0, rd_data returns the stored value.
- Scoreboard update at each rising clk:
  - Any enabled write to register r clears busy[r].
  - iss_en to r sets busy[r].
  - Set and clear of the same r in one cycle: set wins (a new producer is in flight).
  - iss_en to an already-busy register keeps it busy (no counting; the issue stage must not reissue to a busy register).
- rd_busy[p] = rd_en[p] & (rd_addr[p] != 0) & busy[rd_addr[p]] & ~(BYPASS & write to rd_addr[p] this cycle).
  - With BYPASS = 0, a same-cycle write does not mask busy.
- busy_vec reflects registered scoreboard state only; it does not include same-cycle effects.
- No X propagation: unwritten registers read as 0 after reset.
- A per-register signal-naming generate block is required for waveform visibility.

Test Plan:
- Reset clear:
  - Stimulus: write 0xDEADBEEF to x5, assert rst_n low asynchronously mid-cycle.
  - Required: rd_data for x5 reads 0 immediately; busy_vec = 0.
- x0 hard-wire:
  - Stimulus: write 0xFFFFFFFF to x0, iss_en to x0, read x0 on all ports.
  - Required: rd_data = 0, rd_busy = 0, busy_vec[0] = 0.
- Write then read:
  - Stimulus: write 0x12345678 to x7, BYPASS = 1, read x7 on port 0 in the same cycle.
  - Required: port 0 returns 0x12345678; a read of x7 next cycle also returns 0x12345678.
  - Stimulus: repeat with BYPASS = 0 after x7 = 0x1.
  - Required: same-cycle read returns 0x1; next-cycle read returns 0x12345678.
- Dual write collision:
  - Stimulus: NUM_WR = 2, port 0 writes 0xAAAA0000 and port 1 writes 0xBBBB0000 to x3 in the same cycle.
  - Required: stored value and bypassed value are 0xBBBB0000.
- Scoreboard:
  - Stimulus: iss_en x9 at cycle 0.
  - Required: busy_vec[9] = 1 at cycle 1; a read of x9 gives rd_busy = 1.
  - Stimulus: write x9 = 0x55 at cycle 3 with BYPASS = 1.
  - Required: rd_busy = 0 and rd_data = 0x55 in cycle 3; busy_vec[9] = 0 at cycle 4.
- Set/clear race:
  - Stimulus: x4 busy; in one cycle, write x4 and iss_en x4.
  - Required: busy_vec[4] stays 1 next cycle and x4 holds the written data.
